// File: rtl/ws2812_rx_decoder.sv
// ws2812_rx_decoder: rebuilds 24-bit GRB pixels and frame boundaries from a WS2812 serial line.
// Latency: pixel_valid 1 cycle after the synchronised last fall; no backpressure, strobes are fire-and-forget.
module ws2812_rx_decoder #(
  parameter int ONE_THRESH   = 30,
  parameter int HIGH_TIMEOUT = 60,
  parameter int RESET_CNT    = 2500,
  parameter int MAX_PIXELS   = 110,
  parameter int IDX_W        = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [23:0]      pixel_data,
  output logic             pixel_valid,
  output logic [IDX_W-1:0] pixel_index,
  output logic             frame_done,
  output logic [IDX_W-1:0] pixel_count,
  output logic             err
);

  localparam int HC_W = $clog2(HIGH_TIMEOUT + 2);
  localparam int LC_W = $clog2(RESET_CNT + 1);
  localparam logic [HC_W-1:0]  HC_SAT    = HC_W'(HIGH_TIMEOUT + 1);
  localparam logic [HC_W-1:0]  HC_TO     = HC_W'(HIGH_TIMEOUT);
  localparam logic [HC_W-1:0]  HC_ONE    = HC_W'(ONE_THRESH);
  localparam logic [LC_W-1:0]  LC_GAP_M1 = LC_W'(RESET_CNT - 1);
  localparam logic [IDX_W-1:0] PIX_MAX   = IDX_W'(MAX_PIXELS);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t           state;
  logic             din_meta, din_s, din_q;
  logic [HC_W-1:0]  high_cnt;
  logic [LC_W-1:0]  low_cnt;
  logic [4:0]       bit_cnt;
  logic [IDX_W-1:0] pix_cnt;
  // Only the first 23 bits are stored; the 24th is merged in on the completing fall.
  logic [22:0]      shift_reg;
  logic             rise, bit_val;

  assign rise    = din_s & ~din_q;
  assign bit_val = (high_cnt >= HC_ONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SYNC;
      din_meta    <= 1'b0;
      din_s       <= 1'b0;
      din_q       <= 1'b0;
      high_cnt    <= '0;
      low_cnt     <= '0;
      bit_cnt     <= '0;
      pix_cnt     <= '0;
      shift_reg   <= '0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      pixel_index <= '0;
      frame_done  <= 1'b0;
      pixel_count <= '0;
      err         <= 1'b0;
    end else begin
      din_meta    <= din;
      din_s       <= din_meta;
      din_q       <= din_s;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        SYNC: begin
          if (din_s) begin
            low_cnt <= '0;
          end else if (low_cnt >= LC_GAP_M1) begin
            low_cnt <= '0;
            state   <= IDLE;
          end else begin
            low_cnt <= low_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (rise) begin
            high_cnt <= HC_W'(1);
            state    <= HIGH;
          end
        end
        HIGH: begin
          if (din_s) begin
            if (high_cnt < HC_SAT) high_cnt <= high_cnt + 1'b1;
            // This cycle would be pulse cycle HIGH_TIMEOUT+1: resynchronise on the next gap.
            if (high_cnt >= HC_TO) begin
              err     <= 1'b1;
              bit_cnt <= '0;
              pix_cnt <= '0;
              low_cnt <= '0;
              state   <= SYNC;
            end
          end else begin
            low_cnt <= LC_W'(1);
            state   <= LOW;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              if (pix_cnt < PIX_MAX) begin
                pixel_valid <= 1'b1;
                pixel_data  <= {shift_reg, bit_val};
                pixel_index <= pix_cnt;
                pix_cnt     <= pix_cnt + 1'b1;
              end else begin
                err <= 1'b1;
              end
            end else begin
              shift_reg <= {shift_reg[21:0], bit_val};
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end
        end
        LOW: begin
          if (rise) begin
            high_cnt <= HC_W'(1);
            state    <= HIGH;
          end else if (low_cnt >= LC_GAP_M1) begin
            if (pix_cnt != '0) begin
              frame_done  <= 1'b1;
              pixel_count <= pix_cnt;
            end
            if (bit_cnt != '0) err <= 1'b1;
            pix_cnt <= '0;
            bit_cnt <= '0;
            low_cnt <= '0;
            state   <= IDLE;
          end else begin
            low_cnt <= low_cnt + 1'b1;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: doc/ws2812_rx_decoder.md
Name: ws2812_rx_decoder

Overview:
- Receives a single-wire WS2812-style serial LED stream, such as the racer's `leds_line` output, and rebuilds the 24-bit GRB words.
- Emits one strobe per pixel, plus an end-of-frame strobe carrying the pixel count.
- Used as the on-chip loopback monitor and as the chained-display input stage for a second racer board.
- All timing is measured in `clk` cycles; the defaults assume a 50 MHz clock.

Parameters:
- ONE_THRESH, 30: a high pulse of at least this many cycles decodes as 1; shorter decodes as 0.
- HIGH_TIMEOUT, 60: a high pulse longer than this many cycles is a protocol error.
- RESET_CNT, 2500: line low for this many consecutive cycles = latch/reset gap (50 us).
- MAX_PIXELS, 110: number of pixels accepted per frame.
- IDX_W, 7: width of pixel_index and pixel_count; must satisfy 2^IDX_W > MAX_PIXELS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- din  in  1  asynchronous serial LED line
- pixel_data  out  24  last decoded word, GRB order, first received bit = bit 23
- pixel_valid  out  1  one-cycle strobe; pixel_data and pixel_index are valid in this cycle
- pixel_index  out  IDX_W  index of the pixel in the current frame, 0-based
- frame_done  out  1  one-cycle strobe when a reset gap ends a non-empty frame
- pixel_count  out  IDX_W  pixels completed in the frame; valid with frame_done
- err  out  1  sticky error flag; cleared only by reset

Behaviour:
- **Reset.** On rst_n=0 at a clk edge: every output goes to 0, all counters are cleared, and the FSM enters SYNC.
- **Input synchronisation.**
  - din passes through a 2-FF synchroniser giving din_s; din_q is din_s delayed one cycle.
  - A rise is din_s=1 with din_q=0. A fall is din_s=0 with din_q=1.
- **Counters.**
  - high_cnt saturates at HIGH_TIMEOUT+1.
  - low_cnt saturates at RESET_CNT.
  - Each counter is sized with $clog2(limit+1).
- **SYNC state.**
  - Counts consecutive din_s=0 cycles; any 1 clears low_cnt.
  - When low_cnt reaches RESET_CNT: go to IDLE. No data is decoded before the first gap, so startup mid-frame is ignored.
- **IDLE state.** On a rise: high_cnt=1, go to HIGH.
- **HIGH state.**
  - Each cycle with din_s=1: high_cnt++.
  - If high_cnt exceeds HIGH_TIMEOUT: set err, discard the partial pixel, go to SYNC.
  - On a fall: bit = (high_cnt >= ONE_THRESH). Shift the bit into the 24-bit shift register MSB-first, bit_cnt++, low_cnt=1, go to LOW.
- **Pixel completion.**
  - When bit_cnt reaches 24, on the cycle after the fall: pixel_valid=1, pixel_data=shift register, pixel_index=pix_cnt.
  - Then pix_cnt++ and bit_cnt=0.
  - Latency from the synchronised fall to pixel_valid is 1 cycle.
- **LOW state.**
  - On a rise: high_cnt=1, go to HIGH.
  - Otherwise low_cnt++. When low_cnt reaches RESET_CNT, the frame ends:
    - frame_done=1 and pixel_count=pix_cnt, but only if pix_cnt>0.
    - If bit_cnt≠0 (partial pixel): set err and drop the bits.
    - Clear pix_cnt and bit_cnt; go to IDLE.
- **Overflow.** Pixels beyond MAX_PIXELS in a frame: pixel_valid is suppressed, err is set, and pix_cnt saturates at MAX_PIXELS.
- **Strobe hold values.** pixel_valid and frame_done are never high in the same cycle. pixel_data, pixel_index and pixel_count hold their values between strobes.
- **Mid-operation reset.** rst_n low mid-frame aborts everything. After release, the FSM re-enters SYNC and needs a full gap before decoding again.
- **Boundary values.**
  - A high pulse of exactly ONE_THRESH decodes as 1; ONE_THRESH-1 decodes as 0.
  - Exactly HIGH_TIMEOUT cycles is legal.
  - Exactly RESET_CNT-1 low cycles is not a gap.

Test Plan:
- **Basic pixel.** Gap, then 24 bits of 0x00FF00 (1 = 40 cycles high/22 low, 0 = 20 high/42 low), then a gap → one pixel_valid with data=0x00FF00 and index=0; then frame_done with pixel_count=1; err=0.
- **Threshold edges.** Pixel with high pulses of 29 and 30 cycles at bits 23/22 → pixel_data[23:22]=2'b01.
- **Full frame.** 110 pixels with data = index×0x010203 → 110 strobes with indices 0..109; frame_done with pixel_count=110. Sending a 111th pixel → no strobe and err=1.
- **Protocol errors.** A 61-cycle high pulse → err=1 and no pixel_valid until gap + new frame. Separately, a 12-bit partial pixel followed by a gap → err=1 and no frame_done (pix_cnt=0).
- **Gap boundary.** Low held 2499 cycles between pixels → decoding continues in the same frame (index 1 follows). Low held 2500 cycles → frame_done, and the next pixel has index 0.
- **Reset.** Assert rst_n=0 after 10 bits → all outputs 0. Release, send a pixel without a preceding gap → no strobe. Send gap + pixel → strobe with index 0.
